multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath. It drives instruction fetch, decode, execute, memory and write-back phases.
- For each instruction it generates immediate-format select, ALU operand, PC-update, data-memory and register-file write controls.
- It sits between the instruction register and the shared datapath: PC, immediate generator, ALU, register file and data memory port.
- Instruction and data memory accesses use req/ready handshakes with arbitrary wait states.

Parameters:
- WIDTH, 32, instruction/data width.
- CNT_WIDTH, 32, width of the retired-instruction counter (optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  WIDTH  instruction register contents; stable from DECODE until return to FETCH.
- imem_ready  input  1  instruction memory has data; ignored unless imem_req=1.
- dmem_ready  input  1  data memory access complete; ignored outside MEM.
- br_taken  input  1  ALU branch-compare result; sampled in EXEC only.
- imem_req  output  1  instruction fetch request.
- ir_we  output  1  instruction register load strobe.
- pc_we  output  1  PC update strobe.
- pc_sel  output  2  0=PC+4, 1=PC+imm, 2=ALU result (JALR).
- imm_sel  output  3  0=I, 1=S, 2=B, 3=J, 4=U, 5=shamt.
- alu_src_b  output  1  0=rs2, 1=immediate.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write.
- rf_we  output  1  register file write enable.
- wb_sel  output  2  0=ALU, 1=memory, 2=PC+4, 3=immediate.
- illegal  output  1  sticky illegal-opcode flag.
- state_o  output  3  current state, for debug.
- instret  output  CNT_WIDTH  retired-instruction count (optional feature).

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low. While rst_n=0, state=IDLE and every output is 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- Reset mid-operation aborts immediately; no pc_we or rf_we is issued for the aborted instruction.
- Outputs are decoded from the registered state plus instr[6:0] and instr[14:12]. Outputs not listed for a state are 0.
- IDLE: all outputs 0; always goes to FETCH next cycle.
- FETCH:
  - imem_req=1, held until imem_ready.
  - ir_we = imem_ready.
  - On imem_ready, go to DECODE.
- DECODE:
  - One cycle; checks the opcode.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0110111. Any other opcode goes to TRAP.
- EXEC (one cycle):
  - imm_sel by class: OP-IMM=I, except funct3 001/101 which use shamt; LOAD=I; JALR=I; STORE=S; BRANCH=B; JAL=J; LUI=U.
  - alu_src_b=1 for every class except R-type and BRANCH.
  - BRANCH: pc_we=1 and pc_sel=br_taken?1:0, then go to FETCH.
  - LOAD and STORE go to MEM; all other classes go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - Both are held until dmem_ready.
  - On dmem_ready: STORE asserts pc_we=1 with pc_sel=0 and goes to FETCH; LOAD goes to WB.
- WB (one cycle, always followed by FETCH):
  - rf_we=1 and pc_we=1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 3 for LUI, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - imm_sel and alu_src_b hold their EXEC values.
- TRAP: illegal=1; all other outputs 0; exit only by reset.
- pc_we is asserted exactly once per retired instruction.
- Zero-wait cycle counts: BRANCH 3; STORE 4; R-type, OP-IMM, JAL, JALR and LUI 4; LOAD 5.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: instret is a CNT_WIDTH counter.
  - Reset value 0.
  - Increments by 1 in every cycle where pc_we=1.
  - Wraps from all-ones to 0.
  - Does not count in TRAP.
- Undefined: instret tied to 0 and no counter flops.

Test Plan:
- Reset in MEM: assert rst_n=0 while dmem_req=1 -> all outputs 0 in the same cycle, state_o=0. After release -> one IDLE cycle, then imem_req=1.
- ADDI 0x00500093, zero-wait memory -> state_o 1,2,3,5. imm_sel=0, alu_src_b=1. In WB: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0.
- LW 0x00802103 with dmem_ready asserted 3 cycles late -> dmem_req=1 and dmem_we=0 for 4 cycles. Then WB with rf_we=1, wb_sel=1. Total 8 cycles.
- BEQ 0x00000463:
  - br_taken=1 -> in EXEC: imm_sel=2, pc_we=1, pc_sel=1; rf_we stays 0.
  - Repeat with br_taken=0 -> pc_sel=0.
- SLLI 0x00301093 -> imm_sel=5. SW 0x00112423 -> imm_sel=1, dmem_we=1, and pc_we only in the dmem_ready cycle.
- Opcode 0x0000007F -> TRAP after DECODE: illegal=1, imem_req=0 for 10+ cycles. With PERF_CNT_EN, instret counts only retired instructions (e.g., 5 after the 5 preceding instructions).

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb with req/ready memory handshakes.
// Optional retired-instruction counter on instret is enabled by defining PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     instr,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 br_taken,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [2:0]           imm_sel,
    output logic                 alu_src_b,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 illegal,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_imm, is_load, is_store, is_branch, is_jalr, is_jal, is_lui, is_legal;
    logic [2:0] imm_sel_dec;
    logic       unused_instr_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign is_r      = (opcode == OP_R);
    assign is_imm    = (opcode == OP_IMM);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_jal    = (opcode == OP_JAL);
    assign is_lui    = (opcode == OP_LUI);
    assign is_legal  = is_r | is_imm | is_load | is_store | is_branch | is_jalr | is_jal | is_lui;
    assign unused_instr_bits = ^{instr[WIDTH-1:15], instr[11:7]};

    // Shift-immediate ops take the shamt field instead of the full I immediate.
    always_comb begin
        imm_sel_dec = 3'd0;
        if (is_imm && (funct3 == 3'b001 || funct3 == 3'b101)) imm_sel_dec = 3'd5;
        else if (is_store)                                    imm_sel_dec = 3'd1;
        else if (is_branch)                                   imm_sel_dec = 3'd2;
        else if (is_jal)                                      imm_sel_dec = 3'd3;
        else if (is_lui)                                      imm_sel_dec = 3'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_branch)                state_d = S_FETCH;
                else if (is_load || is_store) state_d = S_MEM;
                else                          state_d = S_WB;
            end
            S_MEM:    if (dmem_ready) state_d = is_store ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        imm_sel   = 3'd0;
        alu_src_b = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                imm_sel   = imm_sel_dec;
                alu_src_b = !(is_r || is_branch);
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? 2'd1 : 2'd0;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_we    = is_store && dmem_ready;
            end
            S_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                imm_sel   = imm_sel_dec;
                alu_src_b = !(is_r || is_branch);
                if (is_load)                wb_sel = 2'd1;
                else if (is_jal || is_jalr) wb_sel = 2'd2;
                else if (is_lui)            wb_sel = 2'd3;
                if (is_jal)       pc_sel = 2'd1;
                else if (is_jalr) pc_sel = 2'd2;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (pc_we && state_q != S_TRAP) instret_d = instret_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output traces built from the phase rules,
// checked every cycle, plus literal pins on cycle counts and the retired count.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic        imem_req;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic [2:0]  imm_sel;
        logic        alu_src_b;
        logic        dmem_req;
        logic        dmem_we;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        illegal;
        logic [2:0]  state;
        logic [31:0] instret;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_req, ir_we, pc_we, alu_src_b, dmem_req, dmem_we, rf_we, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  imm_sel, state_o;
    logic [31:0] instret;

    int     errors = 0;
    int     checks = 0;
    outs_t  exp_q;
    logic   exp_valid = 1'b0;
    string  cur_name = "reset";
    int     m_cnt = 0;
    int     n;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .imm_sel(imm_sel), .alu_src_b(alu_src_b), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .state_o(state_o), .instret(instret)
    );

    function automatic outs_t dut_outs();
        outs_t a;
        a = '{imem_req, ir_we, pc_we, pc_sel, imm_sel, alu_src_b, dmem_req, dmem_we,
              rf_we, wb_sel, illegal, state_o, instret};
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Instruction-class rules in plain terms.
    function automatic int m_class(input logic [31:0] i);
        case (i[6:0])
            7'b0110011: return 1;  // R
            7'b0010011: return 2;  // OP-IMM
            7'b0000011: return 3;  // LOAD
            7'b0100011: return 4;  // STORE
            7'b1100011: return 5;  // BRANCH
            7'b1100111: return 6;  // JALR
            7'b1101111: return 7;  // JAL
            7'b0110111: return 8;  // LUI
            default:    return 0;
        endcase
    endfunction

    function automatic logic [2:0] m_imm(input logic [31:0] i);
        case (m_class(i))
            2:       return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'd5 : 3'd0;
            4:       return 3'd1;
            5:       return 3'd2;
            7:       return 3'd3;
            8:       return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic rst, input logic imr,
                         input logic dmr, input logic br, input outs_t e_in);
        outs_t e;
        e = e_in;
`ifdef PERF_CNT_EN
        e.instret = m_cnt;
`else
        e.instret = 32'd0;
`endif
        if (e.pc_we) m_cnt++;
        @(negedge clk);
        rst_n      = rst;
        instr      = ins;
        imem_ready = imr;
        dmem_ready = dmr;
        br_taken   = br;
        exp_q      = e;
        exp_valid  = 1'b1;
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins, input int iw,
                             input int dw, input logic br, input logic abort_mem,
                             output int cycles);
        outs_t e;
        int    c;
        int    cls;
        cur_name = name;
        cls = m_class(ins);
        c = 0;
        for (int k = 0; k < iw; k++) begin
            e = '0; e.imem_req = 1; e.state = 3'd1;
            drive(ins, 1, 0, 1, 1, e); c++;
        end
        e = '0; e.imem_req = 1; e.ir_we = 1; e.state = 3'd1;
        drive(ins, 1, 1, 1, 1, e); c++;
        e = '0; e.state = 3'd2;
        drive(ins, 1, 1, 1, 1, e); c++;
        if (cls != 0) begin
            e = '0; e.state = 3'd3;
            e.imm_sel = m_imm(ins);
            e.alu_src_b = (cls != 1 && cls != 5);
            if (cls == 5) begin e.pc_we = 1; e.pc_sel = br ? 2'd1 : 2'd0; end
            drive(ins, 1, 1, 1, br, e); c++;
            if (cls == 3 || cls == 4) begin
                for (int k = 0; k < dw; k++) begin
                    e = '0; e.state = 3'd4; e.dmem_req = 1; e.dmem_we = (cls == 4);
                    drive(ins, 1, 1, 0, 1, e); c++;
                    if (abort_mem) begin
                        #3 rst_n = 1'b0;
                        #1 check({name, " async reset outputs"}, 64'(dut_outs()), 64'(0));
                        m_cnt = 0;
                        cycles = c;
                        return;
                    end
                end
                e = '0; e.state = 3'd4; e.dmem_req = 1; e.dmem_we = (cls == 4);
                e.pc_we = (cls == 4);
                drive(ins, 1, 1, 1, 1, e); c++;
            end
            if (cls != 4 && cls != 5) begin
                e = '0; e.state = 3'd5; e.rf_we = 1; e.pc_we = 1;
                e.imm_sel = m_imm(ins);
                e.alu_src_b = (cls != 1);
                e.wb_sel = (cls == 3) ? 2'd1 : (cls == 6 || cls == 7) ? 2'd2 : (cls == 8) ? 2'd3 : 2'd0;
                e.pc_sel = (cls == 7) ? 2'd1 : (cls == 6) ? 2'd2 : 2'd0;
                drive(ins, 1, 1, 1, 1, e); c++;
            end
        end
        cycles = c;
    endtask

    task automatic compare_loop();
        outs_t a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_valid) begin
                a = dut_outs();
                checks++;
                if (a !== exp_q) begin
                    errors++;
                    $display("FAIL %s t=%0t: outputs got %h, expected %h", cur_name, $time, a, exp_q);
                end
            end
        end
    endtask

    initial begin
        outs_t z;
        z = '0;
        fork
            compare_loop();
        join_none

        drive(32'h0, 0, 1, 1, 1, z);
        drive(32'h0, 0, 0, 0, 0, z);
        drive(32'h0, 1, 1, 1, 1, z);
        run_instr("lw_abort", 32'h00802103, 0, 5, 0, 1, n);
        cur_name = "reset_hold";
        drive(32'h00802103, 0, 1, 1, 1, z);
        cur_name = "idle_after_reset";
        drive(32'h00802103, 1, 1, 1, 1, z);

        run_instr("addi", 32'h00500093, 0, 0, 0, 0, n);
        check("addi cycles", 64'(n), 64'd4);
        run_instr("lw", 32'h00802103, 0, 3, 0, 0, n);
        check("lw late cycles", 64'(n), 64'd8);
        run_instr("beq_taken", 32'h00000463, 0, 0, 1, 0, n);
        check("beq cycles", 64'(n), 64'd3);
        run_instr("beq_not", 32'h00000463, 0, 0, 0, 0, n);
        run_instr("slli", 32'h00301093, 2, 0, 0, 0, n);
        check("slli cycles", 64'(n), 64'd6);
        check("slli imm_sel", 64'(m_imm(32'h00301093)), 64'd5);
        run_instr("sw", 32'h00112423, 0, 2, 0, 0, n);
        check("sw cycles", 64'(n), 64'd6);
        run_instr("add", 32'h002081b3, 0, 0, 0, 0, n);
        run_instr("srai", 32'h4030d093, 0, 0, 0, 0, n);
        run_instr("jal", 32'h008000ef, 0, 0, 0, 0, n);
        run_instr("jalr", 32'h000080e7, 1, 0, 0, 0, n);
        run_instr("lui", 32'h123450b7, 0, 0, 0, 0, n);
        check("lui cycles", 64'(n), 64'd4);

        run_instr("trap_decode", 32'h0000007f, 0, 0, 0, 0, n);
        cur_name = "trap";
        for (int k = 0; k < 12; k++) begin
            z = '0; z.illegal = 1; z.state = 3'd7;
            drive(32'h0000007f, 1, 1, 1, 1, z);
        end
        @(negedge clk);
        exp_valid = 1'b0;
        #2;
`ifdef PERF_CNT_EN
        check("instret retired", 64'(instret), 64'd11);
`else
        check("instret tied", 64'(instret), 64'd0);
`endif
        check("trap illegal sticky", 64'({illegal, imem_req, state_o}), 64'({1'b1, 1'b0, 3'd7}));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
